// File: rtl/reg_access_pkg.sv
// Shared types and defaults for the host-side holding-register access controller.
package reg_access_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned ERRW_DEF  = 4;

  // Saturation value of the default-width mismatch counter
  localparam logic [ERRW_DEF-1:0] ERR_SAT = '1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WRITE,
    RD_EN,
    RD_SMP,
    DONE
  } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Sequences host write/read/clear requests into strobes for an 8-bit holding register,
// with optional write read-back verification and a saturating mismatch counter.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter bit          VERIFY = 1'b1,
  parameter int unsigned ERRW   = ERRW_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             req,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] reg_data,
  output logic             reg_ewr_n,
  output logic             reg_edy_n,
  output logic             reg_rst,
  input  logic [WIDTH-1:0] reg_q
);

  localparam logic [ERRW-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic             is_wr, is_wr_nx;
  logic [WIDTH-1:0] rdata_nx, reg_data_nx;
  logic [ERRW-1:0]  err_cnt_nx;
  logic             err_nx;
  logic             busy_nx, ack_nx, ewr_n_nx, edy_n_nx, rst_nx;

  // Next state plus next values of every registered output
  always_comb begin
    state_nx    = state;
    is_wr_nx    = is_wr;
    rdata_nx    = rdata;
    reg_data_nx = reg_data;
    err_cnt_nx  = err_cnt;
    err_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          is_wr_nx = 1'b0;
        end else if (req) begin
          is_wr_nx = we;
          if (we) begin
            state_nx    = WRITE;
            reg_data_nx = wdata;
          end else begin
            state_nx = RD_EN;
          end
        end
      end
      CLEAR:  state_nx = DONE;
      WRITE:  state_nx = VERIFY ? RD_EN : DONE;
      RD_EN:  state_nx = RD_SMP;
      RD_SMP: begin
        state_nx = DONE;
        rdata_nx = reg_q;
        // is_wr only reaches RD_SMP on the verify path
        if (is_wr && (reg_q != reg_data)) begin
          err_nx = 1'b1;
          if (err_cnt != CNT_MAX) err_cnt_nx = err_cnt + ERRW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx  = (state_nx != IDLE);
    ack_nx   = (state_nx == DONE);
    ewr_n_nx = (state_nx != WRITE);
    edy_n_nx = !((state_nx == RD_EN) || (state_nx == RD_SMP));
    rst_nx   = (state_nx == CLEAR);
  end

  // State and output registers; reset also pulses reg_rst to clear the register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      err_cnt   <= '0;
      reg_data  <= '0;
      reg_ewr_n <= 1'b1;
      reg_edy_n <= 1'b1;
      reg_rst   <= 1'b1;
    end else begin
      state     <= state_nx;
      is_wr     <= is_wr_nx;
      busy      <= busy_nx;
      ack       <= ack_nx;
      err       <= err_nx;
      rdata     <= rdata_nx;
      err_cnt   <= err_cnt_nx;
      reg_data  <= reg_data_nx;
      reg_ewr_n <= ewr_n_nx;
      reg_edy_n <= edy_n_nx;
      reg_rst   <= rst_nx;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl driving a falling-edge holding register model, checked
// cycle by cycle against a transaction-timeline model plus directed literal checks.
`timescale 1ns/1ps
module tb_reg_access_ctrl;
  import reg_access_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned EW  = 4;
  localparam bit          VER = 1'b1;

  typedef enum int {K_NONE, K_WR, K_RD, K_CLR} kind_t;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, ack, err;
  logic [W-1:0]  rdata, reg_data, reg_q;
  logic [EW-1:0] err_cnt;
  logic          reg_ewr_n, reg_edy_n, reg_rst;

  logic          stuck = 1'b0;
  logic [W-1:0]  reg_store = '0;

  int nvec = 0, nmis = 0, cyc = 0, ack_cnt = 0;

  reg_access_ctrl #(.WIDTH(W), .VERIFY(VER), .ERRW(EW)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .we(we), .clr(clr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err), .err_cnt(err_cnt),
    .reg_data(reg_data), .reg_ewr_n(reg_ewr_n), .reg_edy_n(reg_edy_n),
    .reg_rst(reg_rst), .reg_q(reg_q)
  );

  always #5 Clock = ~Clock;

  // Holding register: latches on the falling edge, output gated by reg_edy_n
  always @(negedge Clock) begin
    if (reg_rst === 1'b1)        reg_store <= '0;
    else if (reg_ewr_n === 1'b0) reg_store <= reg_data;
  end
  assign reg_q = (stuck || reg_edy_n) ? '0 : reg_store;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input kind_t k);
    case (k)
      K_WR:    return VER ? 4 : 2;
      K_RD:    return 3;
      K_CLR:   return 2;
      default: return 0;
    endcase
  endfunction

  // Timeline model: an accepted transaction at cycle t0 determines outputs at t0+1..t0+lat
  kind_t         kind = K_NONE;
  int            t0 = 0, lat = 0, k = 0;
  bit            valid = 1'b0, m_rstp = 1'b0, m_errf = 1'b0, act = 1'b0;
  logic [W-1:0]  m_rdata = '0, m_regdata = '0, mem = '0, v = '0;
  logic [EW-1:0] m_cnt = '0;
  logic          s_rst, s_req, s_clr, s_we, s_stuck;
  logic [W-1:0]  s_wd;

  always @(posedge Clock) begin
    s_rst = Reset; s_req = req; s_clr = clr; s_we = we; s_wd = wdata; s_stuck = stuck;
    cyc++;
    if (s_rst) begin
      valid = 1'b1; kind = K_NONE; m_rstp = 1'b1;
      m_rdata = '0; m_regdata = '0; m_cnt = '0; m_errf = 1'b0;
    end else if (valid) begin
      m_rstp = 1'b0;
      k = cyc - t0;
      if (kind != K_NONE && k == lat && (kind == K_RD || (kind == K_WR && VER))) begin
        v = s_stuck ? '0 : mem;
        m_rdata = v;
        if (kind == K_WR && v != m_regdata) begin
          m_errf = 1'b1;
          if (m_cnt != ERR_SAT) m_cnt++;
        end
      end
      if (kind == K_NONE || cyc - 1 > t0 + lat) begin
        if (s_clr || s_req) begin
          kind   = s_clr ? K_CLR : (s_we ? K_WR : K_RD);
          t0     = cyc - 1;
          lat    = lat_of(kind);
          m_errf = 1'b0;
          if (kind == K_WR) m_regdata = s_wd;
        end
      end
    end
    #1;
    if (valid) begin
      k   = cyc - t0;
      act = (kind != K_NONE) && k >= 1 && k <= lat;
      check("busy",      32'(busy),      32'(act));
      check("ack",       32'(ack),       32'(act && k == lat));
      check("err",       32'(err),       32'(act && k == lat && m_errf));
      check("reg_ewr_n", 32'(reg_ewr_n), 32'(!(act && kind == K_WR && k == 1)));
      check("reg_edy_n", 32'(reg_edy_n),
            32'(!(act && ((kind == K_RD && k <= 2) || (kind == K_WR && VER && (k == 2 || k == 3))))));
      check("reg_rst",   32'(reg_rst),   32'(m_rstp || (act && kind == K_CLR && k == 1)));
      check("rdata",     32'(rdata),     32'(m_rdata));
      check("err_cnt",   32'(err_cnt),   32'(m_cnt));
      check("reg_data",  32'(reg_data),  32'(m_regdata));
      check("strobe_overlap", 32'(!reg_ewr_n && !reg_edy_n), 32'(0));
      check("rst_overlap",    32'(reg_rst && (!reg_ewr_n || !reg_edy_n)), 32'(0));
      if (ack === 1'b1) ack_cnt++;
      if (m_rstp || (act && kind == K_CLR && k == 1)) mem = '0;
      else if (act && kind == K_WR && k == 1)         mem = m_regdata;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin tick(); n++; end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic send(input logic c, input logic r, input logic w, input logic [W-1:0] d,
                      output int n_acc);
    wait_idle();
    clr = c; req = r; we = w; wdata = d;
    n_acc = cyc;
    tick();
    clr = 1'b0; req = 1'b0;
  endtask

  task automatic wait_ack(input int n_acc, output int l, output int ewr_lo, output int edy_lo,
                          output int rst_hi);
    ewr_lo = 0; edy_lo = 0; rst_hi = 0;
    for (int n = 0; n < 20; n++) begin
      ewr_lo += int'(reg_ewr_n === 1'b0);
      edy_lo += int'(reg_edy_n === 1'b0);
      rst_hi += int'(reg_rst === 1'b1);
      if (ack === 1'b1) break;
      tick();
    end
    l = (ack === 1'b1) ? cyc - n_acc : -1;
  endtask

  int na, l, ew, ed, rh, a0;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_reg_rst", 32'(reg_rst), 32'(1));
    check("rst_strobes", 32'({reg_ewr_n, reg_edy_n}), 32'(2'b11));
    Reset = 1'b0;
    tick();
    check("rst_release", 32'(reg_rst), 32'(0));

    // Verified write of A5
    send(1'b0, 1'b1, 1'b1, 8'hA5, na);
    wait_ack(na, l, ew, ed, rh);
    check("wr_lat", 32'(l), 32'(4));
    check("wr_ewr_cycles", 32'(ew), 32'(1));
    check("wr_edy_cycles", 32'(ed), 32'(2));
    check("wr_rdata", 32'(rdata), 32'(8'hA5));
    check("wr_err", 32'(err), 32'(0));

    // Read after write of 3C
    send(1'b0, 1'b1, 1'b1, 8'h3C, na);
    wait_ack(na, l, ew, ed, rh);
    send(1'b0, 1'b1, 1'b0, 8'h00, na);
    wait_ack(na, l, ew, ed, rh);
    check("rd_lat", 32'(l), 32'(3));
    check("rd_rdata", 32'(rdata), 32'(8'h3C));
    check("rd_edy_cycles", 32'(ed), 32'(2));
    check("rd_ewr_cycles", 32'(ew), 32'(0));

    // clr and req together: clear wins
    send(1'b1, 1'b1, 1'b1, 8'h77, na);
    wait_ack(na, l, ew, ed, rh);
    check("clr_lat", 32'(l), 32'(2));
    check("clr_rst_cycles", 32'(rh), 32'(1));
    check("clr_ewr_cycles", 32'(ew), 32'(0));
    send(1'b0, 1'b1, 1'b0, 8'h00, na);
    wait_ack(na, l, ew, ed, rh);
    check("clr_then_rd", 32'(rdata), 32'(8'h00));

    // Stuck register: every verified write mismatches; counter saturates
    stuck = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(1'b0, 1'b1, 1'b1, 8'hFF, na);
      wait_ack(na, l, ew, ed, rh);
      check("stuck_err", 32'(err), 32'(1));
    end
    check("err_cnt_sat", 32'(err_cnt), 32'(4'hF));

    // Reset during WRITE
    send(1'b0, 1'b1, 1'b1, 8'h42, na);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_wr_busy", 32'(busy), 32'(0));
    check("rst_wr_rst", 32'(reg_rst), 32'(1));
    check("rst_wr_cnt", 32'(err_cnt), 32'(0));
    tick();

    // Reset during RD_SMP after one more mismatch
    send(1'b0, 1'b1, 1'b1, 8'h81, na);
    wait_ack(na, l, ew, ed, rh);
    check("cnt_one", 32'(err_cnt), 32'(1));
    tick();
    send(1'b0, 1'b1, 1'b1, 8'h24, na);
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_smp_ack", 32'({ack, err}), 32'(0));
    check("rst_smp_rst", 32'(reg_rst), 32'(1));
    check("rst_smp_cnt", 32'(err_cnt), 32'(0));
    stuck = 1'b0;
    tick();

    // Request while busy is ignored
    send(1'b0, 1'b1, 1'b1, 8'h5A, na);
    a0 = ack_cnt;
    req = 1'b1; we = 1'b1; wdata = 8'h11;
    tick();
    req = 1'b0;
    wait_ack(na, l, ew, ed, rh);
    repeat (4) tick();
    check("busy_ign_acks", 32'(ack_cnt - a0), 32'(1));
    check("busy_ign_rdata", 32'(rdata), 32'(8'h5A));
    check("busy_ign_regdata", 32'(reg_data), 32'(8'h5A));

    // Random traffic including clears, resets and stuck register periods
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 7) == 0);
      req   = ($urandom_range(0, 2) == 0);
      we    = 1'($urandom_range(0, 1));
      wdata = W'($urandom);
      if ($urandom_range(0, 99) == 0) stuck = ~stuck;
      tick();
    end
    Reset = 1'b0; clr = 1'b0; req = 1'b0; stuck = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
